mem_initiator: RTL and testbench

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator_pkg.sv | 22 ++
 rtl/mem_initiator_if.sv | 31 +++
 rtl/mem_initiator_wait_timer.sv | 42 ++++
 rtl/mem_initiator.sv | 122 ++++++++++++
 tb/tb_mem_initiator.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the host-side initiator and the memory-side FSM:
// state encoding, operation codes and the wait-timer width.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int TIMER_W = 8;

    // Echoed operation must match the one that was issued.
    function automatic logic rw_matches(input logic op, input logic rw);
        return (op == rw);
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Host handshake plus memory-side select/op/valid bus of the initiator,
// with the initiator (master) and the host/memory environment (slave) views.
interface mem_initiator_if #(
    parameter int ADDR_W = 4
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic              host_wdata;
    logic              host_ready;
    logic              host_done;
    logic              host_err;
    logic              host_rdata;
    logic              select;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic              wdata;
    logic              valid;
    logic              rw;
    logic              rdata;

    modport master (
        input  host_req, host_we, host_addr, host_wdata, valid, rw, rdata,
        output host_ready, host_done, host_err, host_rdata, select, op, addr, wdata
    );

    modport slave (
        output host_req, host_we, host_addr, host_wdata, valid, rw, rdata,
        input  host_ready, host_done, host_err, host_rdata, select, op, addr, wdata
    );
endinterface

// File: rtl/mem_initiator_wait_timer.sv
// Saturating 8-bit wait counter; expired is high once TIMEOUT-1 cycles of
// enable have elapsed since the last clear.
module wait_timer
    import mem_initiator_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: clear wins, then count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_initiator.sv
// Host-side initiator: accepts one host access, drives select/op/addr/wdata to
// the memory-side FSM and reports completion, rw mismatch or timeout.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_initiator_if.master       bus
);
    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wdata_q, wdata_d;
    logic              select_q, select_d;
    logic              host_ready_q, host_ready_d;
    logic              host_done_q, host_done_d;
    logic              host_err_q, host_err_d;
    logic              host_rdata_q, host_rdata_d;
    logic              valid_s;
    logic              expired_s;

    // A response only counts while the cell is actually selected.
    assign valid_s = select_q & bus.valid;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_SETUP),
        .enable_i  (state_q == ST_ACCESS),
        .expired_o (expired_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= 1'b0;
            select_q     <= 1'b0;
            host_ready_q <= 1'b1;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
            host_rdata_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            select_q     <= select_d;
            host_ready_q <= host_ready_d;
            host_done_q  <= host_done_d;
            host_err_q   <= host_err_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Next-state logic; a response in the last allowed cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.host_req) state_d = ST_SETUP;
                else              state_d = ST_IDLE;
            end
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (valid_s || expired_s) state_d = ST_RELEASE;
                else                      state_d = ST_ACCESS;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output next values, registered so no input reaches an output combinationally.
    always_comb begin
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        host_err_d   = host_err_q;
        host_rdata_d = host_rdata_q;
        if ((state_q == ST_IDLE) && bus.host_req) begin
            op_d    = bus.host_we;
            addr_d  = bus.host_addr;
            wdata_d = bus.host_wdata;
        end else begin
            op_d    = op_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
        if ((state_q == ST_ACCESS) && valid_s) begin
            if (rw_matches(op_q, bus.rw)) begin
                host_err_d = 1'b0;
                if (op_q == OP_READ) host_rdata_d = bus.rdata;
                else                 host_rdata_d = host_rdata_q;
            end else begin
                host_err_d = 1'b1;
            end
        end else if ((state_q == ST_ACCESS) && expired_s) begin
            host_err_d = 1'b1;
        end else begin
            host_err_d = host_err_q;
        end
        select_d     = (state_d == ST_ACCESS);
        host_ready_d = (state_d == ST_IDLE);
        host_done_d  = (state_d == ST_RELEASE);
    end

    assign bus.op         = op_q;
    assign bus.addr       = addr_q;
    assign bus.wdata      = wdata_q;
    assign bus.select     = select_q;
    assign bus.host_ready = host_ready_q;
    assign bus.host_done  = host_done_q;
    assign bus.host_err   = host_err_q;
    assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator: a transaction-level model predicts
// latency, select duration, error and read data from the responder timing.
module tb_mem_initiator;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;
    logic model_rdata;

    mem_initiator_if #(.ADDR_W(4)) bus ();

    mem_initiator #(.ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One host access; dly = select cycle index (0-based) of the response, >= TO means none.
    task automatic run_txn(input logic we, input logic [3:0] a, input logic wd,
                           input int dly, input logic r_rw, input logic r_rd, input bit keep);
        int   k;
        int   sel_cnt;
        int   first_sel;
        int   done_k;
        bit   done_seen;
        int   exp_sel;
        int   exp_lat;
        logic exp_err;
        logic exp_rd;
        k = 0;
        while (!bus.host_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_before_req", bus.host_ready, 1);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = wd;
        bus.valid      = 1'b0;
        @(negedge clk);
        if (!keep) begin
            bus.host_req   = 1'b0;
            bus.host_we    = 1'($urandom);
            bus.host_addr  = 4'($urandom);
            bus.host_wdata = 1'($urandom);
        end
        check_eq("accepted", bus.host_ready, 0);
        k = 1;
        sel_cnt = 0;
        first_sel = 0;
        done_k = 0;
        done_seen = 1'b0;
        while (!done_seen && k < TO + 10) begin
            if (k > 1) @(negedge clk);
            if (bus.select) begin
                sel_cnt++;
                if (first_sel == 0) first_sel = k;
                check_eq("op_held", bus.op, we);
                check_eq("addr_held", bus.addr, a);
                if (we) check_eq("wdata_held", bus.wdata, wd);
            end
            if (bus.host_done) begin
                done_seen = 1'b1;
                done_k = k;
                bus.valid = 1'b0;
            end else if (bus.select) begin
                bus.valid = (sel_cnt - 1 == dly);
                bus.rw    = (sel_cnt - 1 == dly) ? r_rw : 1'($urandom);
                bus.rdata = (sel_cnt - 1 == dly) ? r_rd : 1'($urandom);
            end else begin
                bus.valid = 1'($urandom);
                bus.rw    = 1'($urandom);
                bus.rdata = 1'($urandom);
            end
            k++;
        end
        if (dly < TO) begin
            exp_sel = dly + 1;
            exp_lat = dly + 3;
            exp_err = (r_rw != we);
        end else begin
            exp_sel = TO;
            exp_lat = TO + 2;
            exp_err = 1'b1;
        end
        exp_rd = (!exp_err && !we) ? r_rd : model_rdata;
        model_rdata = exp_rd;
        check_eq("done_seen", done_seen, 1);
        check_eq("latency", done_k, exp_lat);
        check_eq("select_cycles", sel_cnt, exp_sel);
        check_eq("select_rise", first_sel, 2);
        check_eq("select_at_done", bus.select, 0);
        check_eq("host_err", bus.host_err, exp_err);
        check_eq("host_rdata", bus.host_rdata, exp_rd);
        @(negedge clk);
        check_eq("done_one_pulse", bus.host_done, 0);
        check_eq("ready_after_done", bus.host_ready, 1);
        check_eq("op_idle_hold", bus.op, we);
        check_eq("addr_idle_hold", bus.addr, a);
        check_eq("rdata_idle_hold", bus.host_rdata, exp_rd);
    endtask

    // Abort an access on its second select cycle and confirm no completion follows.
    task automatic reset_abort();
        int k;
        int sel_cnt;
        bit any_done;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 4'($urandom);
        bus.valid     = 1'b0;
        @(negedge clk);
        bus.host_req = 1'b0;
        sel_cnt = 0;
        k = 0;
        while (sel_cnt < 2 && k < 20) begin
            @(negedge clk);
            if (bus.select) sel_cnt++;
            k++;
        end
        check_eq("abort_reached_access", sel_cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 1'b0;
        check_eq("abort_select", bus.select, 0);
        check_eq("abort_ready", bus.host_ready, 1);
        check_eq("abort_done", bus.host_done, 0);
        check_eq("abort_rdata", bus.host_rdata, 0);
        any_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_done = any_done | bus.host_done;
        end
        check_eq("abort_no_late_done", any_done, 0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        model_rdata = 1'b0;
        reset = 1'b1;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 4'hF;
        bus.host_wdata = 1'b1;
        bus.valid      = 1'b0;
        bus.rw         = 1'b0;
        bus.rdata      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", bus.host_ready, 1);
        check_eq("rst_done", bus.host_done, 0);
        check_eq("rst_err", bus.host_err, 0);
        check_eq("rst_rdata", bus.host_rdata, 0);
        check_eq("rst_select", bus.select, 0);
        check_eq("rst_op", bus.op, 0);
        check_eq("rst_addr", bus.addr, 0);
        check_eq("rst_wdata", bus.wdata, 0);
        bus.host_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 4'h5, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 4'hA, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run_txn(1'b0, 4'h3, 1'b0, 1000, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 4'h7, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 4'h9, 1'b0, TO - 1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 4'h2, 1'b0, TO, 1'b0, 1'b1, 1'b0);
        run_txn(1'b1, 4'h1, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 4'h2, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 4'h3, 1'b1, 0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic r_we;
            logic r_rw;
            r_we = 1'($urandom);
            r_rw = ($urandom_range(0, 3) == 0) ? ~r_we : r_we;
            run_txn(r_we, 4'($urandom), 1'($urandom), $urandom_range(0, TO + 2),
                    r_rw, 1'($urandom), 1'($urandom));
        end
        bus.host_req = 1'b0;
        @(negedge clk);

        reset_abort();
        run_txn(1'b0, 4'hC, 1'b0, 3, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", err_cnt);
        $fatal(1);
    end

endmodule
